dht11_sensor_emulator: RTL and testbench

//  Responder end of the DHT11 single-wire protocol: emulates a DHT11 sensor on the shared open-drain line.

---
 rtl/dht11_sensor_emulator.sv | 207 ++++++++++++++++++++
 tb/tb_dht11_sensor_emulator.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_sensor_emulator.sv
// DHT11 sensor emulator: answers a host start pulse with the presence
// response and a 40-bit humidity/temperature frame on an open-drain line.
module dht11_sensor_emulator #(
  parameter int unsigned START_MIN_LOW = 500_000,
  parameter int unsigned T_WAIT        = 1_500,
  parameter int unsigned T_RESP_LOW    = 4_000,
  parameter int unsigned T_RESP_HIGH   = 4_000,
  parameter int unsigned T_BIT_LOW     = 2_500,
  parameter int unsigned T_ZERO_HIGH   = 1_300,
  parameter int unsigned T_ONE_HIGH    = 3_500,
  parameter int unsigned T_EOF_LOW     = 2_500,
  parameter int unsigned T_HOLDOFF     = 50_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       line_in,
  output logic       line_drive_low,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_frac,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_frac,
  input  logic       corrupt_checksum,
  output logic       busy,
  output logic       frame_done,
  output logic       short_start,
  output logic [7:0] frames_sent
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_LOW,
    S_WAIT,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_EOF_LOW,
    S_HOLDOFF
  } state_t;

  localparam logic [21:0] MIN_LOW  = 22'(START_MIN_LOW);
  localparam logic [21:0] END_WAIT = 22'(T_WAIT - 1);
  localparam logic [21:0] END_RLO  = 22'(T_RESP_LOW - 1);
  localparam logic [21:0] END_RHI  = 22'(T_RESP_HIGH - 1);
  localparam logic [21:0] END_BLO  = 22'(T_BIT_LOW - 1);
  localparam logic [21:0] END_ZERO = 22'(T_ZERO_HIGH - 1);
  localparam logic [21:0] END_ONE  = 22'(T_ONE_HIGH - 1);
  localparam logic [21:0] END_EOF  = 22'(T_EOF_LOW - 1);
  localparam logic [21:0] END_HOLD = 22'(T_HOLDOFF - 1);

  state_t      state_q, state_d;
  logic        line_m_q;
  logic        line_s_q;
  logic [21:0] cnt_q, cnt_d;
  logic [39:0] shreg_q, shreg_d;
  logic [5:0]  bit_idx_q, bit_idx_d;
  logic        drive_q, drive_d;
  logic        frame_done_q, frame_done_d;
  logic        short_start_q, short_start_d;
  logic [7:0]  frames_q, frames_d;
  logic [21:0] cnt_end;
  logic        cnt_done;
  logic [7:0]  chk;

  assign chk = (hum_int + hum_frac + temp_int + temp_frac)
             ^ {7'd0, corrupt_checksum};

  always_comb begin
    cnt_end = '1;
    unique case (state_q)
      S_WAIT:      cnt_end = END_WAIT;
      S_RESP_LOW:  cnt_end = END_RLO;
      S_RESP_HIGH: cnt_end = END_RHI;
      S_BIT_LOW:   cnt_end = END_BLO;
      S_BIT_HIGH:  cnt_end = shreg_q[39] ? END_ONE : END_ZERO;
      S_EOF_LOW:   cnt_end = END_EOF;
      S_HOLDOFF:   cnt_end = END_HOLD;
      default:     cnt_end = '1;
    endcase
  end

  assign cnt_done = (cnt_q == cnt_end);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 22'd1;
    shreg_d       = shreg_q;
    bit_idx_d     = bit_idx_q;
    frame_done_d  = 1'b0;
    short_start_d = 1'b0;
    frames_d      = frames_q;
    drive_d       = (state_q == S_RESP_LOW) ||
                    (state_q == S_BIT_LOW)  ||
                    (state_q == S_EOF_LOW);
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable && !line_s_q) begin
          state_d = S_START_LOW;
          cnt_d   = 22'd1;
        end
      end
      S_START_LOW: begin
        if (!line_s_q) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 22'd1;
        end else begin
          cnt_d = '0;
          if (cnt_q >= MIN_LOW) begin
            state_d = S_WAIT;
          end else begin
            state_d       = S_IDLE;
            short_start_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_done) begin
          state_d   = S_RESP_LOW;
          cnt_d     = '0;
          shreg_d   = {hum_int, hum_frac, temp_int, temp_frac, chk};
          bit_idx_d = '0;
        end
      end
      S_RESP_LOW: begin
        if (cnt_done) begin
          state_d = S_RESP_HIGH;
          cnt_d   = '0;
        end
      end
      S_RESP_HIGH: begin
        if (cnt_done) begin
          state_d = S_BIT_LOW;
          cnt_d   = '0;
        end
      end
      S_BIT_LOW: begin
        if (cnt_done) begin
          state_d = S_BIT_HIGH;
          cnt_d   = '0;
        end
      end
      S_BIT_HIGH: begin
        if (cnt_done) begin
          cnt_d     = '0;
          shreg_d   = {shreg_q[38:0], 1'b0};
          bit_idx_d = bit_idx_q + 6'd1;
          state_d   = (bit_idx_q == 6'd39) ? S_EOF_LOW : S_BIT_LOW;
        end
      end
      S_EOF_LOW: begin
        if (cnt_done) begin
          state_d      = S_HOLDOFF;
          cnt_d        = '0;
          frame_done_d = 1'b1;
          frames_d     = frames_q + 8'd1;
        end
      end
      S_HOLDOFF: begin
        if (cnt_done) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      line_m_q      <= 1'b1;
      line_s_q      <= 1'b1;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      shreg_q       <= '0;
      bit_idx_q     <= '0;
      drive_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      short_start_q <= 1'b0;
      frames_q      <= '0;
    end else begin
      line_m_q      <= line_in;
      line_s_q      <= line_m_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      bit_idx_q     <= bit_idx_d;
      drive_q       <= drive_d;
      frame_done_q  <= frame_done_d;
      short_start_q <= short_start_d;
      frames_q      <= frames_d;
    end
  end

  // Busy only once the host low has become a genuine start request.
  assign busy = (state_q != S_IDLE) &&
                !((state_q == S_START_LOW) && (cnt_q < MIN_LOW));

  assign line_drive_low = drive_q;
  assign frame_done     = frame_done_q;
  assign short_start    = short_start_q;
  assign frames_sent    = frames_q;

endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// Directed bench for dht11_sensor_emulator with scaled-down timings.
// The bench decodes the frame from line_drive_low run lengths.
module tb_dht11_sensor_emulator;

  localparam int MIN  = 20;
  localparam int TW   = 3;
  localparam int RLO  = 4;
  localparam int RHI  = 4;
  localparam int BLO  = 2;
  localparam int ZHI  = 1;
  localparam int OHI  = 3;
  localparam int EOFL = 3;
  localparam int HOLD = 24;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       host_low = 1'b0;
  logic       line_in;
  logic       line_drive_low;
  logic [7:0] hum_int = 8'd0;
  logic [7:0] hum_frac = 8'd0;
  logic [7:0] temp_int = 8'd0;
  logic [7:0] temp_frac = 8'd0;
  logic       corrupt_checksum = 1'b0;
  logic       busy;
  logic       frame_done;
  logic       short_start;
  logic [7:0] frames_sent;

  int n_checks = 0;
  int n_fails = 0;
  int fd_cnt = 0;
  int ss_cnt = 0;
  int busy_cnt = 0;
  int drv_cnt = 0;

  assign line_in = ~(host_low | line_drive_low);

  always #5 clock = ~clock;

  dht11_sensor_emulator #(
    .START_MIN_LOW(MIN), .T_WAIT(TW),
    .T_RESP_LOW(RLO), .T_RESP_HIGH(RHI),
    .T_BIT_LOW(BLO), .T_ZERO_HIGH(ZHI),
    .T_ONE_HIGH(OHI), .T_EOF_LOW(EOFL),
    .T_HOLDOFF(HOLD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .line_in(line_in),
    .line_drive_low(line_drive_low),
    .hum_int(hum_int),
    .hum_frac(hum_frac),
    .temp_int(temp_int),
    .temp_frac(temp_frac),
    .corrupt_checksum(corrupt_checksum),
    .busy(busy),
    .frame_done(frame_done),
    .short_start(short_start),
    .frames_sent(frames_sent)
  );

  always @(negedge clock) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (short_start === 1'b1) ss_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (line_drive_low === 1'b1) drv_cnt++;
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_start(input int len);
    @(negedge clock);
    host_low = 1'b1;
    repeat (len) @(negedge clock);
    host_low = 1'b0;
  endtask

  task automatic run_len(input logic v, output int n);
    n = 0;
    while (line_drive_low === v && n < 1000) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic wait_resp(output bit ok);
    int t;
    t = 0;
    while (line_drive_low !== 1'b1 && t < 500) begin
      @(negedge clock);
      t++;
    end
    ok = (t < 500);
  endtask

  // Decodes the response and the 40 data bits; ok drops on any bad timing.
  task automatic capture_frame(output logic [39:0] f, output bit ok);
    int n;
    bit got;
    f = '0;
    wait_resp(got);
    ok = got;
    if (got) begin
      run_len(1'b1, n);
      if (n != RLO) ok = 0;
      run_len(1'b0, n);
      if (n != RHI) ok = 0;
      for (int i = 0; i < 40; i++) begin
        run_len(1'b1, n);
        if (n != BLO) ok = 0;
        run_len(1'b0, n);
        if (n == OHI) f = {f[38:0], 1'b1};
        else if (n == ZHI) f = {f[38:0], 1'b0};
        else ok = 0;
      end
      run_len(1'b1, n);
      if (n != EOFL) ok = 0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 1000) begin
      @(negedge clock);
      t++;
    end
    ok = (t < 1000);
  endtask

  initial begin
    logic [39:0] f;
    bit ok;
    bit ok2;
    bit tmo;
    int fd0;
    int ss0;
    int bc0;
    int dc0;
    int n;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_drive", {63'd0, line_drive_low}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_frame_done", {63'd0, frame_done}, 64'd0);
    check("rst_short", {63'd0, short_start}, 64'd0);
    check("rst_frames", {56'd0, frames_sent}, 64'd0);

    hum_int = 8'd35;
    temp_int = 8'd24;
    fd0 = fd_cnt;
    host_start(2 * MIN);
    capture_frame(f, ok);
    check("t1_timing", {63'd0, ok}, 64'd1);
    check("t1_frame", {24'd0, f}, 64'h23_00_18_00_3B);
    // A short host pulse inside the holdoff window must be ignored.
    ss0 = ss_cnt;
    host_start(5);
    wait_idle(ok);
    check("t1_idle", {63'd0, ok}, 64'd1);
    check("t1_fd", 64'(fd_cnt - fd0), 64'd1);
    check("t1_frames", {56'd0, frames_sent}, 64'd1);
    check("hold_ignored", 64'(ss_cnt - ss0), 64'd0);
    repeat (10) @(negedge clock);
    check("hold_no_start", {63'd0, busy}, 64'd0);

    ss0 = ss_cnt;
    bc0 = busy_cnt;
    dc0 = drv_cnt;
    host_start(MIN - 1);
    repeat (60) @(negedge clock);
    check("short_pulse", 64'(ss_cnt - ss0), 64'd1);
    check("short_drive", 64'(drv_cnt - dc0), 64'd0);
    check("short_busy", 64'(busy_cnt - bc0), 64'd0);

    hum_int = 8'hFF;
    hum_frac = 8'hFF;
    temp_int = 8'hFF;
    temp_frac = 8'hFF;
    corrupt_checksum = 1'b1;
    host_start(2 * MIN);
    capture_frame(f, ok);
    check("corrupt_timing", {63'd0, ok}, 64'd1);
    check("corrupt_frame", {24'd0, f}, 64'hFF_FF_FF_FF_FD);
    wait_idle(ok);
    corrupt_checksum = 1'b0;

    fd0 = fd_cnt;
    host_start(2 * MIN);
    wait_resp(ok);
    check("rst_mid_resp", {63'd0, ok}, 64'd1);
    run_len(1'b1, n);
    run_len(1'b0, n);
    for (int i = 0; i < 20; i++) begin
      run_len(1'b1, n);
      run_len(1'b0, n);
    end
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_drive", {63'd0, line_drive_low}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_frames", {56'd0, frames_sent}, 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("rst_mid_no_fd", 64'(fd_cnt - fd0), 64'd0);

    hum_int = 8'd35;
    hum_frac = 8'd0;
    temp_int = 8'd24;
    temp_frac = 8'd0;
    host_start(2 * MIN);
    capture_frame(f, ok);
    check("post_rst_timing", {63'd0, ok}, 64'd1);
    check("post_rst_frame", {24'd0, f}, 64'h23_00_18_00_3B);
    wait_idle(ok);

    hum_int = 8'h11;
    hum_frac = 8'h22;
    temp_int = 8'h33;
    temp_frac = 8'h44;
    host_start(2 * MIN);
    fork
      capture_frame(f, ok);
      begin
        repeat (60) @(negedge clock);
        hum_int = 8'hA5;
        temp_frac = 8'h5A;
        corrupt_checksum = 1'b1;
        enable = 1'b0;
      end
    join
    check("latch_timing", {63'd0, ok}, 64'd1);
    check("latch_frame", {24'd0, f}, 64'h11_22_33_44_AA);
    wait_idle(ok);
    check("latch_frames", {56'd0, frames_sent}, 64'd2);
    bc0 = busy_cnt;
    dc0 = drv_cnt;
    host_start(2 * MIN);
    repeat (100) @(negedge clock);
    check("dis_drive", 64'(drv_cnt - dc0), 64'd0);
    check("dis_busy", 64'(busy_cnt - bc0), 64'd0);

    enable = 1'b1;
    corrupt_checksum = 1'b0;
    hum_int = 8'd0;
    hum_frac = 8'd0;
    temp_int = 8'd0;
    temp_frac = 8'd0;
    tmo = 1'b0;
    for (int k = 0; k < 254; k++) begin
      fd0 = fd_cnt;
      host_start(MIN);
      n = 0;
      while (fd_cnt == fd0 && n < 1000) begin
        @(negedge clock);
        n++;
      end
      if (n >= 1000) tmo = 1'b1;
      wait_idle(ok2);
      if (!ok2) tmo = 1'b1;
      if (k == 0) check("min_low_frame", {56'd0, frames_sent}, 64'd3);
    end
    check("wrap_timeouts", {63'd0, tmo}, 64'd0);
    check("wrap_frames", {56'd0, frames_sent}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
